// File: rtl/sound_pkg.sv
// Shared sound-block definitions: FSM state encoding, sample width and the silence value.
// Used by the ROM arbiter and the sound register block.
package sound_pkg;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] SILENCE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/sound_rom_arbiter_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins.
// Purely combinational so a rotating-priority wrapper can reuse it later.
module prio_enc #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan from the top so the last match written is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_rom_arbiter.sv
// Shares the 8-bit sound ROM read port between the voices. Each sample tick starts one
// fetch round over the active voices, lowest index first, using the load/ready handshake.
module sound_rom_arbiter
    import sound_pkg::*;
#(
    parameter int NUM_VOICES = 5,
    parameter int ADDR_W     = 24,
    parameter int TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic [NUM_VOICES*ADDR_W-1:0]   voice_addr,
    input  logic                           clr_err,
    output logic                           rom_load,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [SAMPLE_W-1:0]            rom_data,
    input  logic                           rom_ready,
    output logic [NUM_VOICES*SAMPLE_W-1:0] sample_data,
    output logic [NUM_VOICES-1:0]          sample_valid,
    output logic                           round_done,
    output logic                           busy,
    output logic                           overrun,
    output logic                           timeout_err
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                                    state_q, state_d;
    logic [NUM_VOICES-1:0]                     pending_q, pending_d;
    logic [IDX_W-1:0]                          sel_q, sel_d;
    logic [ADDR_W-1:0]                         addr_q, addr_d;
    logic [CNT_W-1:0]                          cnt_q, cnt_d;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0]       samp_q, samp_d;
    logic [NUM_VOICES-1:0]                     valid_q, valid_d;
    logic                                      done_q, done_d;
    logic                                      overrun_q, overrun_d;
    logic                                      tmo_q, tmo_d;

    logic [NUM_VOICES-1:0][ADDR_W-1:0]         vaddr;
    logic [IDX_W-1:0]                          pe_idx;
    logic                                      pe_any;
    logic [CNT_W-1:0]                          cnt_inc;
    logic                                      fetch_end;

    assign vaddr = voice_addr;

    prio_enc #(
        .N     (NUM_VOICES),
        .IDX_W (IDX_W)
    ) u_prio (
        .req (pending_q),
        .idx (pe_idx),
        .any (pe_any)
    );

    assign cnt_inc = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        samp_d    = samp_q;
        valid_d   = '0;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        tmo_d     = tmo_q;
        rom_load  = 1'b0;
        rom_addr  = addr_q;
        fetch_end = 1'b0;

        // Clear first so a same-cycle set below takes precedence.
        if (clr_err) begin
            overrun_d = 1'b0;
            tmo_d     = 1'b0;
        end
        if (sample_tick && state_q != ST_IDLE) overrun_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    pending_d = voice_active;
                    for (int i = 0; i < NUM_VOICES; i++)
                        if (!voice_active[i]) samp_d[i] = SILENCE;
                    if (|voice_active) state_d = ST_ISSUE;
                    else               done_d  = 1'b1;
                end
            end
            ST_ISSUE: begin
                // Address is taken live here so upstream counters may move mid-round.
                sel_d    = pe_idx;
                addr_d   = vaddr[pe_idx];
                rom_addr = vaddr[pe_idx];
                rom_load = pe_any;
                cnt_d    = '0;
                if (pe_any) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (rom_ready) begin
                    samp_d[sel_q]    = rom_data;
                    valid_d[sel_q]   = 1'b1;
                    pending_d[sel_q] = 1'b0;
                    fetch_end        = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        tmo_d            = 1'b1;
                        pending_d[sel_q] = 1'b0;
                        fetch_end        = 1'b1;
                    end
                end
                if (fetch_end) begin
                    if (|pending_d) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            samp_q    <= '0;
            valid_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            samp_q    <= samp_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            tmo_q     <= tmo_d;
        end
    end

    assign sample_data  = samp_q;
    assign sample_valid = valid_q;
    assign round_done   = done_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;
    assign timeout_err  = tmo_q;

endmodule

// File: doc/sound_rom_arbiter.md
Name: sound_rom_arbiter

Overview:
- Shares the single 8-bit sound ROM read port between the background voice and the effect voices.
- On each sample tick it fetches one byte per active voice, in fixed priority order, using the ROM load/ready handshake.
- It holds each fetched byte as that voice's current sample for the mixer.
- Sits between the sound register/duration logic, which supplies per-voice addresses and active flags, and the ROM interface.

Parameters:
- NUM_VOICES, 5, voice count; voice 0 = background, 1..NUM_VOICES-1 = sfx0..
- ADDR_W, 24, ROM address width.
- TIMEOUT, 255, maximum WAIT cycles per fetch before it is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle pulse; starts a fetch round
- voice_active  in  NUM_VOICES  per-voice enable, sampled on sample_tick
- voice_addr  in  NUM_VOICES*ADDR_W  flat per-voice ROM addresses; voice i at [i*ADDR_W +: ADDR_W]
- clr_err  in  1  clears the overrun and timeout_err flags
- rom_load  out  1  one-cycle ROM read strobe
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  8  ROM read data, valid with rom_ready
- rom_ready  in  1  ROM data-valid handshake
- sample_data  out  NUM_VOICES*8  flat per-voice current sample bytes
- sample_valid  out  NUM_VOICES  per-voice one-cycle pulse when that voice's sample updates
- round_done  out  1  one-cycle pulse at the end of a round
- busy  out  1  high while not IDLE
- overrun  out  1  sticky: sample_tick arrived while busy
- timeout_err  out  1  sticky: a fetch timed out

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; pending mask 0; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - On sample_tick: pending <= voice_active.
  - Voices with voice_active=0 get sample_data <= 8'h00 (silence) in that same cycle; no sample_valid for them.
  - pending nonzero -> ISSUE.
  - pending zero -> stay in IDLE and pulse round_done on the next cycle.
- ISSUE:
  - Select the lowest-index set pending bit (fixed priority; background first).
  - rom_addr <= that voice's voice_addr.
  - rom_load=1 for exactly this cycle; clear the timeout counter.
  - Next state: WAIT.
- WAIT:
  - rom_addr holds its value; rom_load=0.
  - rom_ready=1: capture rom_data into the selected voice's sample_data, pulse its sample_valid for one cycle, clear its pending bit.
  - rom_ready=0: increment the timeout counter. When the counter reaches TIMEOUT, set timeout_err, leave that voice's sample unchanged, clear its pending bit.
  - After either exit: if other pending bits remain -> ISSUE; otherwise -> IDLE with round_done pulsed in the cycle after the exit.
- rom_ready is ignored in IDLE and ISSUE (stale ready must not capture).
- Minimum cost is 2 cycles per voice. rom_load is first asserted 1 cycle after the tick is sampled. With ready returned immediately, a 5-voice round completes in 10 cycles plus 1.
- Addresses are sampled at ISSUE, not at the tick, so the upstream address counters may advance mid-round.
- sample_tick while busy: ignored (the round in progress is not disturbed) and overrun <= 1.
- clr_err=1 clears overrun/timeout_err. If a set event occurs in the same cycle, set wins.
- voice_active changes mid-round have no effect until the next tick.
- Reset mid-round aborts immediately: rom_load drops asynchronously and all samples are zeroed.
- The timeout counter is sized to clog2(TIMEOUT+1) and saturates; no wrap.

Decomposition:
- Shared package sound_pkg: the state encoding localparams (IDLE/ISSUE/WAIT), SAMPLE_W=8, SILENCE=8'h00. The sound register block reuses these.
- One sub-module: prio_enc, a parameterised lowest-set-bit priority encoder (NUM_VOICES in, index + any-set out). It is combinational, and a future round-robin variant can reuse it.

Test Plan:
- Reset: assert rst=0 mid-WAIT -> rom_load=0 and all sample_data=0 immediately; after release, state=IDLE and busy=0.
- Full round: voice_active=5'b11111, voice i addr=24'h100+i, ROM ready 1 cycle after load returning 8'hA0+i -> rom_addr sequence 100..104, sample_data voice i = A0+i, sample_valid pulses in order 0..4, round_done one cycle after the last capture.
- Sparse: voice_active=5'b10010 -> only voices 1 and 4 fetched; voices 0, 2, 3 read 8'h00; no sample_valid on 0, 2, 3.
- Empty: voice_active=0 -> no rom_load; round_done pulses 1 cycle after the tick.
- Timeout: TIMEOUT=4, rom_ready held low for voice 2 -> after 4 WAIT cycles timeout_err=1, voice 2 sample unchanged, voice 3 fetch proceeds; clr_err clears the flag.
- Overrun: second sample_tick 3 cycles into a 5-voice round -> overrun=1, the round completes unchanged, no extra rom_load; stale rom_ready high during ISSUE causes no capture.
